// File: rtl/sign_gen_pkg.sv
// ---------------------------------------------------------------------------
// sign_gen_pkg
// Shared definitions for the sine-ROM waveform sequencer:
//   - ROM depth and default field widths
//   - sequencer state encoding (enum for readability, plain constants for
//     the FSM register so legacy code can compare against raw values)
// No ports.
// ---------------------------------------------------------------------------
package sign_gen_pkg;

    localparam int ROM_DEPTH   = 1024;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_STEP_W  = 10;
    localparam int DEF_BURST_W = 8;
    localparam int DEF_GAP_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/sign_gen_seq_if.sv
// ---------------------------------------------------------------------------
// sign_gen_seq_if
// Control/status bundle between the capture-side controller (master) and
// the sine sequencer (slave).
//   start, abort            : master -> slave requests
//   step, burst_len, gap_len: master -> slave burst configuration
//   rom_addr, sample_valid  : slave -> master ROM read address and qualifier
//   period_done, busy, done : slave -> master status
// ---------------------------------------------------------------------------
interface sign_gen_seq_if #(
    parameter int ADDR_W  = sign_gen_pkg::DEF_ADDR_W,
    parameter int STEP_W  = sign_gen_pkg::DEF_STEP_W,
    parameter int BURST_W = sign_gen_pkg::DEF_BURST_W,
    parameter int GAP_W   = sign_gen_pkg::DEF_GAP_W
);
    logic               start;
    logic               abort;
    logic [STEP_W-1:0]  step;
    logic [BURST_W-1:0] burst_len;
    logic [GAP_W-1:0]   gap_len;
    logic [ADDR_W-1:0]  rom_addr;
    logic               sample_valid;
    logic               period_done;
    logic               busy;
    logic               done;

    modport master (
        output start, abort, step, burst_len, gap_len,
        input  rom_addr, sample_valid, period_done, busy, done
    );

    modport slave (
        input  start, abort, step, burst_len, gap_len,
        output rom_addr, sample_valid, period_done, busy, done
    );
endinterface

// File: rtl/sign_gen_phase_acc.sv
// ---------------------------------------------------------------------------
// sign_gen_phase_acc
// Phase accumulator for the ROM address. Wraps modulo 2**ADDR_W; the carry
// out of the add marks a period boundary.
//   clk_dac, reset_n : clock, async active-low reset
//   clr              : synchronous clear (wins over en)
//   en               : advance by step this cycle
//   step             : phase increment (STEP_W <= ADDR_W)
//   acc              : current phase
//   acc_nxt          : wrapped phase after adding step
//   carry            : acc + step overflows 2**ADDR_W
// ---------------------------------------------------------------------------
module sign_gen_phase_acc #(
    parameter int ADDR_W = 10,
    parameter int STEP_W = 10
) (
    input  logic              clk_dac,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              en,
    input  logic [STEP_W-1:0] step,
    output logic [ADDR_W-1:0] acc,
    output logic [ADDR_W-1:0] acc_nxt,
    output logic              carry
);
    logic [ADDR_W:0] sum;

    assign sum     = {1'b0, acc} + (ADDR_W+1)'(step);
    assign acc_nxt = sum[ADDR_W-1:0];
    assign carry   = sum[ADDR_W];

    always_ff @(posedge clk_dac or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_nxt;
        end
    end
endmodule

// File: rtl/sign_gen_seq.sv
// ---------------------------------------------------------------------------
// sign_gen_seq
// Sequencer for the 1024-entry sine ROM: steps the ROM address by a
// programmable phase increment, plays burst_len full periods, stays silent
// for gap_len cycles, then pulses done.
//   clk_dac : DAC sample clock
//   reset_n : asynchronous active-low reset
//   bus     : sign_gen_seq_if.slave (start/abort/config in, address/status out)
// Build option: define SIGN_GEN_SEQ_LOOP_EN to repeat bursts until abort.
// ---------------------------------------------------------------------------
module sign_gen_seq
    import sign_gen_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int STEP_W  = DEF_STEP_W,
    parameter int BURST_W = DEF_BURST_W,
    parameter int GAP_W   = DEF_GAP_W
) (
    input  logic          clk_dac,
    input  logic          reset_n,
    sign_gen_seq_if.slave bus
);
`ifdef SIGN_GEN_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic [1:0]         state;
    logic [STEP_W-1:0]  step_q;
    logic [BURST_W-1:0] burst_q;
    logic [GAP_W-1:0]   gap_q;
    logic [BURST_W-1:0] per_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [ADDR_W-1:0]  acc;
    logic [ADDR_W-1:0]  acc_nxt;
    logic               carry;
    logic               in_run;
    logic               last_carry;
    logic               acc_clr;

    assign in_run     = (state == ST_RUN);
    // The carry that completes the burst_len-th period ends the run.
    assign last_carry = in_run && carry && (per_cnt == burst_q - BURST_W'(1));
    // Accumulator restarts from phase 0 on every (re)entry into RUN.
    assign acc_clr    = bus.abort || !in_run || last_carry;

    sign_gen_phase_acc #(
        .ADDR_W (ADDR_W),
        .STEP_W (STEP_W)
    ) u_phase_acc (
        .clk_dac (clk_dac),
        .reset_n (reset_n),
        .clr     (acc_clr),
        .en      (in_run),
        .step    (step_q),
        .acc     (acc),
        .acc_nxt (acc_nxt),
        .carry   (carry)
    );

    always_ff @(posedge clk_dac or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            step_q           <= '0;
            burst_q          <= '0;
            gap_q            <= '0;
            per_cnt          <= '0;
            gap_cnt          <= '0;
            bus.rom_addr     <= '0;
            bus.sample_valid <= 1'b0;
            bus.period_done  <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else if (bus.abort) begin
            state            <= ST_IDLE;
            per_cnt          <= '0;
            gap_cnt          <= '0;
            bus.rom_addr     <= '0;
            bus.sample_valid <= 1'b0;
            bus.period_done  <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            bus.period_done <= 1'b0;
            bus.done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        step_q  <= (bus.step == '0) ? STEP_W'(1) : bus.step;
                        burst_q <= bus.burst_len;
                        gap_q   <= bus.gap_len;
                        per_cnt <= '0;
                        if (bus.burst_len == '0) begin
                            state    <= ST_DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state            <= ST_RUN;
                            bus.busy         <= 1'b1;
                            bus.sample_valid <= 1'b1;
                            bus.rom_addr     <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (carry) begin
                        bus.period_done <= 1'b1;
                    end
                    if (last_carry) begin
                        // The wrap cycle is already the first silent cycle,
                        // so even a zero gap leaves one busy, silent cycle.
                        state            <= ST_GAP;
                        gap_cnt          <= GAP_W'(1);
                        bus.sample_valid <= 1'b0;
                        bus.rom_addr     <= '0;
                    end else begin
                        bus.rom_addr <= acc_nxt;
                        if (carry) begin
                            per_cnt <= per_cnt + BURST_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt >= gap_q) begin
                        state    <= ST_DONE;
                        bus.done <= 1'b1;
                        bus.busy <= LOOP_EN;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    if (LOOP_EN && (burst_q != '0)) begin
                        state            <= ST_RUN;
                        per_cnt          <= '0;
                        bus.busy         <= 1'b1;
                        bus.sample_valid <= 1'b1;
                        bus.rom_addr     <= '0;
                    end else begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
